scanner_stream: RTL

Parametrised scanner front-end: buffers incoming samples in a DEPTH-entry FIFO, announces fill thresholds to the output driver as 8-bit serial command frames, and drains the buffer as a command+data frame once the link is granted. It sits between the sample source and the inter-node serial link, and is the multi-sample, configurable-threshold successor of the single-counter scanner node.

---
 rtl/scanner_stream.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/scanner_stream.sv
// scanner_stream: buffers samples in a FIFO, announces fill thresholds as 8-bit serial
// command frames and drains the buffer as one 0x07-headed data frame once the link is granted.
module scanner_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned TH_READY = 8,
  parameter int unsigned TH_START = 9,
  parameter int unsigned BIT_DIV  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_scan,
  input  logic                       peer_half,
  input  logic                       ready_in,
  input  logic                       sample_valid,
  input  logic [DATA_W-1:0]          sample_in,
  output logic                       ser_clk,
  output logic                       ser_data,
  output logic                       ser_busy,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic [1:0]                 state,
  output logic                       overflow
);

  localparam int unsigned FillW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  // Shift register wide enough for a command byte or one sample, MSB-aligned.
  localparam int unsigned ShW   = (DATA_W > 8) ? DATA_W : 8;
  localparam int unsigned BitW  = $clog2(ShW + 1);
  localparam int unsigned DivW  = $clog2(BIT_DIV);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StStandby  = 2'd2,
    StTransfer = 2'd3
  } stateT;

  logic [DATA_W-1:0] mem [DEPTH];

  stateT            stateQ;
  logic [FillW-1:0] fillQ;
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic [2:0]       pendQ;      // bit0=0x02, bit1=0x03, bit2=0x04
  logic             overflowQ;

  logic             busyQ;
  logic             dataFrameQ; // current frame is the data frame
  logic             inEntryQ;   // current word is a FIFO entry, not the header
  logic [DivW-1:0]  divCnt;
  logic [BitW-1:0]  bitLeft;
  logic [FillW-1:0] entLeft;
  logic [ShW-1:0]   shReg;

  logic             wrEn;
  logic [FillW-1:0] fillInc;
  logic             dropSample;
  logic [2:0]       pendSet;
  logic [2:0]       cmdClr;
  logic [7:0]       cmdCode;
  logic             flush;
  logic             cmdStart;
  logic             dataStart;
  logic             bitEnd;
  logic             wordEnd;
  logic             popEn;
  logic             dataDone;
  logic [PtrW-1:0]  memRdAddr;
  logic [DATA_W-1:0] memRd;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Decode writes, threshold crossings, serializer start conditions and word boundaries.
  always_comb begin
    wrEn       = (stateQ == StActive) && sample_valid && (fillQ < FillW'(DEPTH));
    fillInc    = fillQ + FillW'(1);
    dropSample = sample_valid &&
                 (((stateQ == StActive) && (fillQ >= FillW'(DEPTH))) ||
                  (stateQ == StStandby) || (stateQ == StTransfer));
    pendSet = 3'b000;
    if (wrEn) begin
      pendSet = {fillInc == FillW'(DEPTH), fillInc == FillW'(TH_START),
                 fillInc == FillW'(TH_READY)};
    end
    // Abort is only possible before the data frame has begun.
    flush    = (stateQ == StTransfer) && !dataFrameQ && peer_half;
    cmdStart = !busyQ && (pendQ != 3'b000) && !flush;
    cmdClr   = 3'b100;
    cmdCode  = 8'h04;
    if (pendQ[0]) begin
      cmdClr  = 3'b001;
      cmdCode = 8'h02;
    end else if (pendQ[1]) begin
      cmdClr  = 3'b010;
      cmdCode = 8'h03;
    end
    dataStart = (stateQ == StTransfer) && !dataFrameQ && !busyQ && (pendQ == 3'b000) &&
                !peer_half;
    bitEnd    = busyQ && (divCnt == DivW'(BIT_DIV - 1));
    wordEnd   = bitEnd && (bitLeft == BitW'(1));
    popEn     = wordEnd && dataFrameQ && inEntryQ;
    dataDone  = wordEnd && dataFrameQ && (entLeft == '0);
    memRdAddr = popEn ? incPtr(rdPtr) : rdPtr;
    memRd     = mem[memRdAddr];
  end

  // Sample storage; written only while scanning.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= sample_in;
    end
  end

  // Control FSM, FIFO bookkeeping, pending commands and frame serializer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      fillQ      <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      pendQ      <= 3'b000;
      overflowQ  <= 1'b0;
      busyQ      <= 1'b0;
      dataFrameQ <= 1'b0;
      inEntryQ   <= 1'b0;
      divCnt     <= '0;
      bitLeft    <= '0;
      entLeft    <= '0;
      shReg      <= '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (start_scan) stateQ <= StActive;
        end
        StActive: begin
          if (wrEn && (fillInc == FillW'(DEPTH))) begin
            stateQ <= ready_in ? StTransfer : StStandby;
          end
        end
        StStandby: begin
          if (ready_in || peer_half) stateQ <= StTransfer;
        end
        StTransfer: begin
          if (flush || dataDone) stateQ <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase

      if (flush || dataDone) begin
        fillQ <= '0;
        wrPtr <= '0;
        rdPtr <= '0;
        pendQ <= 3'b000;
      end else begin
        if (wrEn) begin
          fillQ <= fillInc;
          wrPtr <= incPtr(wrPtr);
        end else if (popEn) begin
          fillQ <= fillQ - FillW'(1);
          rdPtr <= incPtr(rdPtr);
        end
        pendQ <= (pendQ & ~(cmdStart ? cmdClr : 3'b000)) | pendSet;
      end

      if (dropSample) overflowQ <= 1'b1;

      if (cmdStart) begin
        busyQ      <= 1'b1;
        dataFrameQ <= 1'b0;
        inEntryQ   <= 1'b0;
        divCnt     <= '0;
        bitLeft    <= BitW'(8);
        entLeft    <= '0;
        shReg      <= ShW'(cmdCode) << (ShW - 8);
      end else if (dataStart) begin
        busyQ      <= 1'b1;
        dataFrameQ <= 1'b1;
        inEntryQ   <= 1'b0;
        divCnt     <= '0;
        bitLeft    <= BitW'(8);
        entLeft    <= fillQ;
        shReg      <= ShW'(8'h07) << (ShW - 8);
      end else if (busyQ) begin
        if (bitEnd) begin
          divCnt <= '0;
          if (wordEnd) begin
            if (entLeft != '0) begin
              shReg    <= ShW'(memRd) << (ShW - DATA_W);
              bitLeft  <= BitW'(DATA_W);
              entLeft  <= entLeft - FillW'(1);
              inEntryQ <= 1'b1;
            end else begin
              busyQ      <= 1'b0;
              dataFrameQ <= 1'b0;
              inEntryQ   <= 1'b0;
              bitLeft    <= '0;
              shReg      <= '0;
            end
          end else begin
            shReg   <= shReg << 1;
            bitLeft <= bitLeft - BitW'(1);
          end
        end else begin
          divCnt <= divCnt + DivW'(1);
        end
      end
    end
  end

  assign state    = stateQ;
  assign fill     = fillQ;
  assign overflow = overflowQ;
  assign ser_busy = busyQ;
  assign ser_clk  = busyQ && (divCnt >= DivW'(BIT_DIV / 2));
  assign ser_data = busyQ && shReg[ShW-1];

endmodule
